// File: rtl/floo_pkg.sv
// Shared constants and elaboration-time configuration checks for the floo VC pipeline.
package floo_pkg;

    localparam int unsigned StallCntW = 32;
    localparam int unsigned MaxDepth  = 4;

    function automatic bit depth_legal(input int unsigned depth);
        return (depth >= 1) && (depth <= MaxDepth);
    endfunction

    function automatic bit stages_legal(input int stages);
        return stages >= 0;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/floo_vc_pipe_stage.sv
// One pipeline stage of one channel: a Depth-entry FIFO per VC feeding a
// round-robin arbiter that locks its grant while the downstream stalls.
module floo_vc_pipe_stage
    import floo_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i,
    output logic [NumVirtChannels-1:0] valid_o,
    input  logic [NumVirtChannels-1:0] ready_i,
    output flit_t                      data_o
);

    localparam int unsigned PtrW = idx_w(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned VcW  = idx_w(NumVirtChannels);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [VcW-1:0]  vc_t;

    flit_t mem_q [NumVirtChannels][Depth];
    flit_t mem_d [NumVirtChannels][Depth];

    ptr_t [NumVirtChannels-1:0] wr_ptr_q, wr_ptr_d;
    ptr_t [NumVirtChannels-1:0] rd_ptr_q, rd_ptr_d;
    cnt_t [NumVirtChannels-1:0] cnt_q, cnt_d;
    vc_t                        rr_q, rr_d;
    vc_t                        lock_vc_q, lock_vc_d;
    logic                       lock_q, lock_d;

    logic [NumVirtChannels-1:0] push, pop, not_empty;
    vc_t                        gnt;
    logic                       gnt_vld;
    int unsigned                idx;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Readiness comes only from the registered fill level, so a pop never
    // frees a slot for the same cycle and nothing depends on ready_i.
    always_comb begin
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            ready_o[v]   = (cnt_q[v] != cnt_t'(Depth));
            not_empty[v] = (cnt_q[v] != '0);
        end
    end

    assign push = valid_i & ready_o;

    always_comb begin
        gnt     = rr_q;
        gnt_vld = 1'b0;
        idx     = 0;
        if (lock_q) begin
            gnt     = lock_vc_q;
            gnt_vld = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NumVirtChannels; i++) begin
                idx = (int'(rr_q) + i) % NumVirtChannels;
                if (!gnt_vld && not_empty[vc_t'(idx)]) begin
                    gnt     = vc_t'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_o = '0;
        if (gnt_vld) valid_o[gnt] = 1'b1;
        data_o = mem_q[gnt][rd_ptr_q[gnt]];
    end

    assign pop = valid_o & ready_i;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            if (push[v]) begin
                mem_d[v][wr_ptr_q[v]] = data_i;
                wr_ptr_d[v]           = ptr_inc(wr_ptr_q[v]);
            end
            if (pop[v]) rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
            case ({push[v], pop[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + cnt_t'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - cnt_t'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
        // Offered but not taken: hold this VC until it is accepted.
        if (|pop) begin
            rr_d   = (gnt == vc_t'(NumVirtChannels - 1)) ? '0 : gnt + vc_t'(1);
            lock_d = 1'b0;
        end else if (gnt_vld) begin
            lock_d    = 1'b1;
            lock_vc_d = gnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/floo_vc_pipe.sv
// Multi-channel virtual-channel pipeline built from floo_vc_pipe_stage.
// Define FLOO_VC_PIPE_PERF_EN to add per-channel stall counters.
module floo_vc_pipe
    import floo_pkg::*;
#(
    parameter int unsigned NumChannels     = 2,
    parameter int unsigned NumVirtChannels = 2,
    parameter int          NumStages       = 1,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
`ifdef FLOO_VC_PIPE_PERF_EN
    input  logic                                          clr_perf_i,
    output logic [NumChannels-1:0][StallCntW-1:0]         stall_cnt_o,
`endif
    input  logic [NumChannels-1:0][NumVirtChannels-1:0]   valid_i,
    output logic [NumChannels-1:0][NumVirtChannels-1:0]   ready_o,
    input  flit_t [NumChannels-1:0]                       data_i,
    output logic [NumChannels-1:0][NumVirtChannels-1:0]   valid_o,
    input  logic [NumChannels-1:0][NumVirtChannels-1:0]   ready_i,
    output flit_t [NumChannels-1:0]                       data_o
);

    if (!depth_legal(Depth)) begin : g_bad_depth
        $error("floo_vc_pipe: Depth must be within 1..4");
    end
    if (!stages_legal(NumStages)) begin : g_bad_stages
        $error("floo_vc_pipe: NumStages must be non-negative");
    end

    if (NumStages == 0) begin : g_wires
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
    end else begin : g_pipe
        for (genvar c = 0; c < NumChannels; c++) begin : g_ch
            logic [NumVirtChannels-1:0] vld [NumStages+1];
            logic [NumVirtChannels-1:0] rdy [NumStages+1];
            flit_t                      dat [NumStages+1];

            assign vld[0]         = valid_i[c];
            assign dat[0]         = data_i[c];
            assign ready_o[c]     = rdy[0];
            assign valid_o[c]     = vld[NumStages];
            assign data_o[c]      = dat[NumStages];
            assign rdy[NumStages] = ready_i[c];

            for (genvar s = 0; s < NumStages; s++) begin : g_stg
                floo_vc_pipe_stage #(
                    .NumVirtChannels (NumVirtChannels),
                    .Depth           (Depth),
                    .flit_t          (flit_t)
                ) u_stage (
                    .clk_i   (clk_i),
                    .rst_ni  (rst_ni),
                    .valid_i (vld[s]),
                    .ready_o (rdy[s]),
                    .data_i  (dat[s]),
                    .valid_o (vld[s+1]),
                    .ready_i (rdy[s+1]),
                    .data_o  (dat[s+1])
                );
            end
        end
    end

`ifdef FLOO_VC_PIPE_PERF_EN
    logic [NumChannels-1:0][StallCntW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (clr_perf_i) begin
                stall_cnt_d[c] = '0;
            end else if ((|(valid_o[c] & ~ready_i[c])) && (stall_cnt_q[c] != '1)) begin
                stall_cnt_d[c] = stall_cnt_q[c] + StallCntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_floo_vc_pipe.sv
// Directed and random checks of floo_vc_pipe against per-VC FIFO queues.
module tb_floo_vc_pipe;
    import floo_pkg::*;

    localparam int NC = 2, NV = 2, NS = 2, D = 2;
    typedef logic [15:0] flit_t;
    typedef struct { flit_t d; int cyc; } ent_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic  [NC-1:0][NV-1:0] valid_i, ready_o, valid_o, ready_i;
    flit_t [NC-1:0]         data_i, data_o;

    logic  [0:0][1:0] d1_valid_i, d1_ready_o, d1_valid_o, d1_ready_i;
    flit_t [0:0]      d1_data_i, d1_data_o;

    logic clr_perf_i;
    logic [NC-1:0][StallCntW-1:0] stall_cnt_o;
    logic [0:0][StallCntW-1:0]    d1_stall_cnt_o;

    floo_vc_pipe #(.NumChannels(NC), .NumVirtChannels(NV), .NumStages(NS), .Depth(D),
                   .flit_t(flit_t)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef FLOO_VC_PIPE_PERF_EN
        .clr_perf_i(clr_perf_i), .stall_cnt_o(stall_cnt_o),
`endif
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
    );

    floo_vc_pipe #(.NumChannels(1), .NumVirtChannels(2), .NumStages(1), .Depth(1),
                   .flit_t(flit_t)) u_d1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef FLOO_VC_PIPE_PERF_EN
        .clr_perf_i(clr_perf_i), .stall_cnt_o(d1_stall_cnt_o),
`endif
        .valid_i(d1_valid_i), .ready_o(d1_ready_o), .data_i(d1_data_i),
        .valid_o(d1_valid_o), .ready_i(d1_ready_i), .data_o(d1_data_o)
    );

    int   errors = 0, checks = 0, cyc = 0;
    bit   lat_chk = 0;
    ent_t mq [NC][NV][$];
    bit   lock_pend [NC];
    logic [NV-1:0] pv [NC];
    flit_t pd [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < NC; c++)
            for (int v = 0; v < NV; v++) n += mq[c][v].size();
        return n;
    endfunction

    // Score the current cycle against the queues, then advance one clock.
    task automatic tick();
        ent_t e;
        for (int c = 0; c < NC; c++) begin
            chk("onehot", 32'($countones(valid_o[c]) <= 1), 1);
            if (lock_pend[c]) begin
                chk("lock_valid", 32'(valid_o[c]), 32'(pv[c]));
                chk("lock_data", 32'(data_o[c]), 32'(pd[c]));
            end
            for (int v = 0; v < NV; v++)
                if (valid_i[c][v] && ready_o[c][v]) mq[c][v].push_back('{data_i[c], cyc});
            for (int v = 0; v < NV; v++) begin
                if (valid_o[c][v] && ready_i[c][v]) begin
                    if (mq[c][v].size() == 0) begin
                        chk("spurious", 32'(valid_o[c][v]), 0);
                    end else begin
                        e = mq[c][v].pop_front();
                        chk("data", 32'(data_o[c]), 32'(e.d));
                        if (lat_chk) chk("latency", 32'(cyc - e.cyc), NS);
                    end
                end
            end
            lock_pend[c] = (valid_o[c] != '0) && ((valid_o[c] & ready_i[c]) == '0);
            pv[c] = valid_o[c];
            pd[c] = data_o[c];
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain(input int maxc);
        valid_i = '0;
        ready_i = '1;
        for (int k = 0; k < maxc && pending() > 0; k++) tick();
        chk("drain", 32'(pending()), 0);
    endtask

    initial begin
        int acc, outs, r;
        flit_t seq, q1 [$];

        rst_ni = 1'b0; clr_perf_i = 1'b0;
        valid_i = '0; ready_i = '1; data_i = '0;
        d1_valid_i = '0; d1_ready_i = '1; d1_data_i = '0;
        for (int c = 0; c < NC; c++) lock_pend[c] = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_ready_o", 32'(ready_o), 32'hf);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_valid_o", 32'(valid_o), 0);
        chk("post_rst_ready_o", 32'(ready_o), 32'hf);

        // Back-to-back stream on channel 0 VC0, two-stage latency each flit.
        lat_chk = 1;
        for (int k = 0; k < 8; k++) begin
            valid_i[0] = 2'b01;
            data_i[0]  = flit_t'(16'h1000 + k);
            chk("stream_ready", 32'(ready_o[0][0]), 1);
            tick();
        end
        drain(10);
        lat_chk = 0;

        // Fill both VCs of channel 0 with the output stalled, then release.
        ready_i[0] = 2'b00;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            valid_i[0] = (k % 2 == 0) ? 2'b01 : 2'b10;
            data_i[0]  = flit_t'(16'h2000 + k);
            if (|(valid_i[0] & ready_o[0])) acc++;
            tick();
        end
        valid_i[0] = '0;
        chk("capacity", 32'(acc), 2 * D * NS);
        chk("full_ready_o", 32'(ready_o[0]), 0);
        ready_i[0] = 2'b11;
        for (int k = 0; k < 8; k++) begin
            chk("alternate", 32'(valid_o[0]), (k % 2 == 0) ? 1 : 2);
            tick();
        end
        drain(10);

        // VC1 granted first on channel 1; later VC0 traffic must not steal it.
        ready_i[1] = 2'b00;
        valid_i[1] = 2'b10; data_i[1] = 16'h3abc;
        tick();
        for (int k = 0; k < 4; k++) begin
            valid_i[1] = 2'b01; data_i[1] = flit_t'(16'h3100 + k);
            tick();
        end
        valid_i[1] = '0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(valid_o[1]), 2);
            chk("hold_data", 32'(data_o[1]), 32'h3abc);
            tick();
        end
        drain(20);

`ifdef FLOO_VC_PIPE_PERF_EN
        ready_i[0] = 2'b00;
        valid_i[0] = 2'b01; data_i[0] = 16'h4000;
        tick();
        valid_i[0] = '0;
        tick();
        clr_perf_i = 1'b1; tick(); clr_perf_i = 1'b0;
        chk("stall_clr0", stall_cnt_o[0], 0);
        repeat (10) tick();
        chk("stall_cnt", stall_cnt_o[0], 10);
        chk("stall_idle_ch", stall_cnt_o[1], 0);
        clr_perf_i = 1'b1; tick(); clr_perf_i = 1'b0;
        chk("stall_clr", stall_cnt_o[0], 0);
        drain(10);
`endif

        // Random traffic and backpressure.
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NC; c++) begin
                r = $urandom_range(0, 2);
                valid_i[c] = (r == 0) ? 2'b00 : 2'(1 << (r - 1));
                data_i[c]  = flit_t'($urandom);
                ready_i[c] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            end
            tick();
        end
        drain(40);

        // Depth-1 single stage: one flit every two cycles.
        acc = 0; outs = 0; seq = 16'h5000;
        d1_valid_i[0] = 2'b01; d1_ready_i[0] = 2'b11; d1_data_i[0] = seq;
        for (int k = 0; k < 20; k++) begin
            if (d1_valid_o[0][0] && d1_ready_i[0][0]) begin
                if (q1.size() == 0) chk("d1_spurious", 32'(d1_valid_o[0][0]), 0);
                else chk("d1_data", 32'(d1_data_o[0]), 32'(q1.pop_front()));
                outs++;
            end
            if (d1_valid_i[0][0] && d1_ready_o[0][0]) begin
                q1.push_back(d1_data_i[0]);
                acc++;
                seq = seq + 16'd1;
            end
            tick();
            d1_data_i[0] = seq;
        end
        d1_valid_i = '0;
        chk("d1_accepted", 32'(acc), 10);
        chk("d1_emitted", 32'(outs), 10);

        // Reset with flits buffered: nothing from before reset may emerge.
        ready_i[0] = 2'b00;
        for (int k = 0; k < 3; k++) begin
            valid_i[0] = 2'b01; data_i[0] = flit_t'(16'h6000 + k);
            tick();
        end
        valid_i[0] = '0;
        chk("pre_rst_valid", 32'(valid_o[0]), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid_o", 32'(valid_o), 0);
        chk("mid_rst_ready_o", 32'(ready_o), 32'hf);
        @(posedge clk_i); #1;
        chk("in_rst_valid_o", 32'(valid_o), 0);
        rst_ni = 1'b1;
        for (int c = 0; c < NC; c++) begin
            lock_pend[c] = 0;
            for (int v = 0; v < NV; v++) mq[c][v].delete();
        end
        ready_i = '1;
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_empty", 32'(valid_o), 0);
            tick();
        end
        chk("post_rst_ready", 32'(ready_o), 32'hf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/floo_vc_pipe.md
FLOO_VC_PIPE -- requirements
Module: floo_vc_pipe

Interface
REQ-001 SHALL have parameter NumChannels, default 2, meaning independent channels (2 = bidirectional link).
REQ-002 SHALL have parameter NumVirtChannels, default 2, meaning VCs sharing one physical data bus per channel.
REQ-003 SHALL have parameter NumStages, default 1, meaning pipeline stages per channel; 0 = wires.
REQ-004 SHALL have parameter Depth, default 2, meaning per-VC buffer entries per stage, legal 1..4.
REQ-005 SHALL have parameter flit_t, default logic, meaning flit payload type.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have ports valid_i, input, and ready_o, output, each [NumChannels][NumVirtChannels], upstream per-VC handshake.
REQ-009 SHALL have port data_i, input, flit_t[NumChannels], upstream flit shared by all VCs of a channel.
REQ-010 SHALL have ports valid_o, output, and ready_i, input, each [NumChannels][NumVirtChannels], downstream per-VC handshake.
REQ-011 SHALL have port data_o, output, flit_t[NumChannels], downstream flit.

Function
REQ-012 Transfer on VC v of channel n SHALL occur when valid and ready are both high at that boundary in the same cycle.
REQ-013 valid_i per channel SHALL be zero or one-hot; valid_o per channel SHALL always be zero or one-hot.
REQ-014 Each stage SHALL hold one FIFO of Depth entries per VC; ready toward upstream = that FIFO not full, registered, with no combinational path from ready_i.
REQ-015 Full FIFO: ready low; pop that cycle SHALL NOT enable a same-cycle push. Empty FIFO: no request. Read/write pointers SHALL wrap modulo Depth.
REQ-016 Stage output SHALL be driven by a round-robin grant among non-empty VCs; pointer moves to granted VC+1 (mod NumVirtChannels) after each handshake.
REQ-017 Grant SHALL lock while valid_o high and ready_i low: same VC, same data, until handshake (valid never withdrawn).
REQ-018 Latency per stage SHALL be exactly 1 cycle (push cycle N, visible cycle N+1); total NumStages cycles.
REQ-019 With Depth>=2 and ready_i held high, throughput SHALL be 1 flit/cycle/channel; Depth=1 SHALL give 1 flit per 2 cycles.
REQ-020 Per-VC flit order SHALL be preserved; no flit dropped or duplicated.
REQ-021 NumStages=0: valid_o=valid_i, ready_o=ready_i, data_o=data_i, no state.

Reset
REQ-022 On rst_ni low, all FIFOs SHALL empty, pointers and arbiter pointers SHALL be 0, counters 0, valid_o 0, ready_o 1 by the first edge after deassertion.
REQ-023 Reset mid-transfer SHALL discard all buffered flits; nothing SHALL be emitted from pre-reset contents.

Configuration
REQ-024 Macro FLOO_VC_PIPE_PERF_EN defined: ports clr_perf_i (input, 1) and stall_cnt_o (output, [NumChannels][32]) SHALL exist; counter increments each cycle with any valid_o high and ready_i low, saturates at 2^32-1, zeroes on clr_perf_i (clear wins over increment).
REQ-025 Macro not defined: those ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-026 Stall counter width constant and the stage-count/Depth legality checks SHALL live in floo_pkg.
REQ-027 One sub-module floo_vc_pipe_stage (per-VC FIFOs plus locking round-robin arbiter, one channel, one stage) SHALL be instantiated NumChannels x NumStages times.

Verification
REQ-028 NumStages=2, Depth=2, VC0 pushes 8 flits back-to-back, ready_i=1 -> flits emerge in order on cycles 2..9, one per cycle.
REQ-029 VC0 and VC1 each hold 4 flits, ready_i=1 -> output alternates VC0,VC1,VC0,... for 8 cycles.
REQ-030 ready_i=0 for 5 cycles with VC1 granted -> valid_o stays one-hot VC1, data_o stable; upstream ready_o drops after 2*Depth*NumStages accepted flits.
REQ-031 Depth=1, NumStages=1, continuous traffic -> exactly 1 flit per 2 cycles.
REQ-032 rst_ni pulsed low with 3 flits buffered -> valid_o=0 during and after reset, no pre-reset flit ever appears.
REQ-033 With FLOO_VC_PIPE_PERF_EN, ready_i=0 for 10 cycles with valid_o high -> stall_cnt_o=10; clr_perf_i pulse -> 0.
